// File: rtl/rv_iopmp_pkg.sv
// Shared types and constants for the IOPMP register/AXI bridges.
package rv_iopmp_pkg;

    // Default bus geometry used by the struct typedefs below.
    localparam int unsigned AXI_ADDR_WIDTH = 64;
    localparam int unsigned AXI_DATA_WIDTH = 64;
    localparam int unsigned AXI_ID_WIDTH   = 8;
    localparam int unsigned AXI_USER_WIDTH = 2;
    localparam int unsigned REG_ADDR_WIDTH = 32;
    localparam int unsigned REG_DATA_WIDTH = 32;

    // AXI channel constants driven by the bridge.
    localparam logic [2:0] SIZE_4B          = 3'd2;
    localparam logic [1:0] BURST_INCR       = 2'b01;
    localparam logic [3:0] CACHE_MODIFIABLE = 4'b0010;

    // Bridge FSM state encoding.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WRITE  = 3'd1;
    localparam state_t ST_WAIT_B = 3'd2;
    localparam state_t ST_READ   = 3'd3;
    localparam state_t ST_WAIT_R = 3'd4;
    localparam state_t ST_RESP   = 3'd5;

    // Register bus request/response.
    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0]   addr;
        logic                        write;
        logic [REG_DATA_WIDTH-1:0]   wdata;
        logic [REG_DATA_WIDTH/8-1:0] wstrb;
        logic                        valid;
    } reg_bus_req_t;

    typedef struct packed {
        logic [REG_DATA_WIDTH-1:0] rdata;
        logic                      error;
        logic                      ready;
    } reg_bus_rsp_t;

    // AXI4 address channel (AW carries atop, AR ignores it).
    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
        logic [5:0]                atop;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_ax_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0]   data;
        logic [AXI_DATA_WIDTH/8-1:0] strb;
        logic                        last;
        logic [AXI_USER_WIDTH-1:0]   user;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [1:0]                resp;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_bus_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_bus_rsp_t;

    // Place a 4-bit register strobe into the 32-bit lane chosen by addr[2].
    function automatic logic [7:0] lane_strb(input logic addr2, input logic [3:0] wstrb);
        return addr2 ? {wstrb, 4'h0} : {4'h0, wstrb};
    endfunction

endpackage

// File: rtl/rv_iopmp_reg_to_axi_master.sv
// Register-bus initiator to AXI4 master bridge. Each register access becomes
// one single-beat AXI transaction; the bridge holds until it responds.
//
// Handshake semantics: on every channel a transfer happens on the rising edge
// where valid and ready are both high; a raised valid stays high with stable
// payload until that edge. The reg side is held by the initiator until
// reg_rsp_o.ready, which pulses for exactly one cycle.
module rv_iopmp_reg_to_axi_master
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned USER_WIDTH     = 2,
    parameter int unsigned REG_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID         = 0,
    parameter type reg_req_t = rv_iopmp_pkg::reg_bus_req_t,
    parameter type reg_rsp_t = rv_iopmp_pkg::reg_bus_rsp_t,
    parameter type axi_req_t = rv_iopmp_pkg::axi_bus_req_t,
    parameter type axi_rsp_t = rv_iopmp_pkg::axi_bus_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output axi_req_t axi_req_o,
    input  axi_rsp_t axi_rsp_i
);

    localparam bit WIDE_BUS = (DATA_WIDTH == 64);

    state_t                      state_q;
    logic [REG_ADDR_WIDTH-1:0]   addr_q;
    logic [REG_DATA_WIDTH-1:0]   wdata_q;
    logic [REG_DATA_WIDTH/8-1:0] wstrb_q;
    logic                        aw_valid_q;
    logic                        w_valid_q;
    logic                        ar_valid_q;
    logic                        b_ready_q;
    logic                        r_ready_q;
    logic                        aw_done_q;
    logic                        w_done_q;
    logic                        r_first_q;
    logic                        rsp_ready_q;
    logic                        rsp_error_q;
    logic [REG_DATA_WIDTH-1:0]   rsp_rdata_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic [DATA_WIDTH-1:0] r_shifted;
    logic [7:0]            strb_full;

    assign aw_hs = aw_valid_q && axi_rsp_i.aw_ready;
    assign w_hs  = w_valid_q && axi_rsp_i.w_ready;

    // Bring the 32-bit lane addressed by addr[2] down to bit 0 of the read data.
    always_comb begin
        r_shifted = axi_rsp_i.r.data >> ((WIDE_BUS && addr_q[2]) ? 32 : 0);
        strb_full = WIDE_BUS ? lane_strb(addr_q[2], wstrb_q) : {4'h0, wstrb_q};
    end

    // Main transaction FSM; every valid/ready and response field is a register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            r_first_q   <= 1'b0;
            rsp_ready_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (reg_req_i.valid) begin
                        addr_q  <= reg_req_i.addr;
                        wdata_q <= reg_req_i.wdata;
                        wstrb_q <= reg_req_i.wstrb;
                        if (reg_req_i.addr[1:0] != 2'b00) begin
                            // Misaligned: answer locally, never touch AXI.
                            rsp_ready_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= ST_RESP;
                        end else if (reg_req_i.write) begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            aw_done_q  <= 1'b0;
                            w_done_q   <= 1'b0;
                            state_q    <= ST_WRITE;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    // AW and W complete independently, possibly in the same cycle.
                    if (aw_hs) begin
                        aw_valid_q <= 1'b0;
                        aw_done_q  <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid_q <= 1'b0;
                        w_done_q  <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        b_ready_q <= 1'b1;
                        state_q   <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (axi_rsp_i.b_valid) begin
                        b_ready_q   <= 1'b0;
                        rsp_error_q <= axi_rsp_i.b.resp[1];
                        rsp_rdata_q <= '0;
                        rsp_ready_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_READ: begin
                    if (axi_rsp_i.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        r_first_q  <= 1'b1;
                        state_q    <= ST_WAIT_R;
                    end
                end
                ST_WAIT_R: begin
                    if (axi_rsp_i.r_valid) begin
                        // Only the first beat carries data; a missing last is
                        // a slave protocol error that we drain and report.
                        r_first_q <= 1'b0;
                        if (r_first_q) begin
                            rsp_rdata_q <= r_shifted[REG_DATA_WIDTH-1:0];
                        end
                        rsp_error_q <= (r_first_q ? 1'b0 : rsp_error_q)
                                     | axi_rsp_i.r.resp[1] | !axi_rsp_i.r.last;
                        if (axi_rsp_i.r.last) begin
                            r_ready_q   <= 1'b0;
                            rsp_ready_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    rsp_ready_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Channel payloads: constants plus latched request fields.
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.id    = ID_WIDTH'(AXI_ID);
        axi_req_o.aw.addr  = ADDR_WIDTH'(addr_q);
        axi_req_o.aw.len   = 8'd0;
        axi_req_o.aw.size  = SIZE_4B;
        axi_req_o.aw.burst = BURST_INCR;
        axi_req_o.aw.cache = CACHE_MODIFIABLE;
        axi_req_o.aw.user  = USER_WIDTH'(0);
        axi_req_o.aw_valid = aw_valid_q;
        axi_req_o.w.data   = {(DATA_WIDTH/32){wdata_q}};
        axi_req_o.w.strb   = strb_full[DATA_WIDTH/8-1:0];
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w.user   = USER_WIDTH'(0);
        axi_req_o.w_valid  = w_valid_q;
        axi_req_o.b_ready  = b_ready_q;
        axi_req_o.ar.id    = ID_WIDTH'(AXI_ID);
        axi_req_o.ar.addr  = ADDR_WIDTH'(addr_q);
        axi_req_o.ar.len   = 8'd0;
        axi_req_o.ar.size  = SIZE_4B;
        axi_req_o.ar.burst = BURST_INCR;
        axi_req_o.ar.cache = CACHE_MODIFIABLE;
        axi_req_o.ar.user  = USER_WIDTH'(0);
        axi_req_o.ar_valid = ar_valid_q;
        axi_req_o.r_ready  = r_ready_q;
    end

    // Register-bus response straight from the response registers.
    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = rsp_rdata_q;
        reg_rsp_o.error = rsp_error_q;
        reg_rsp_o.ready = rsp_ready_q;
    end

    // Response fields the bridge has no use for.
    logic unused_rsp_bits;
    assign unused_rsp_bits = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.b.resp[0],
                               axi_rsp_i.r.id, axi_rsp_i.r.user, axi_rsp_i.r.resp[0],
                               r_shifted[DATA_WIDTH-1:REG_DATA_WIDTH]};

endmodule
